// File: rtl/board_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : board_io_pkg
// Brief    : Shared constants and helpers for the board I/O front-end.
// Revision : 1.0 - initial release
// ============================================================================
package board_io_pkg;

  // 10 ms of debounce at a 12.5 MHz core clock.
  localparam int DEBOUNCE_10MS_12M5 = 125000;

  // Default LED brightness resolution.
  localparam int PWM_BITS_DEFAULT = 8;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_io_debounce.sv
`default_nettype none
// ============================================================================
// Module   : board_io_debounce
// Brief    : Single switch channel: synchroniser, persistence counter,
//            stable level and one-cycle rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
module board_io_debounce
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_12M5
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;

  // Last synchroniser stage is the only copy of the pin the logic looks at.
  assign s = sync[SYNC_STAGES-1];

  // Shift the asynchronous pin through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles;
  // any return to the current level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s;
        cnt   <= '0;
        rise  <= s;
        fall  <= ~s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/board_io_bank.sv
`default_nettype none
// ============================================================================
// Module   : board_io_bank
// Brief    : Board I/O front-end: debounced switches with change pulses and
//            PWM-dimmed, registered LED drive.
// Revision : 1.0 - initial release
// ============================================================================
module board_io_bank
  import board_io_pkg::*;
#(
  parameter int NUM_SW          = 16,
  parameter int NUM_LED         = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_12M5,
  parameter int PWM_BITS        = PWM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SW-1:0]   i_sw,
  output logic [NUM_SW-1:0]   o_sw_db,
  output logic [NUM_SW-1:0]   o_sw_rise,
  output logic [NUM_SW-1:0]   o_sw_fall,
  input  logic [NUM_LED-1:0]  i_led,
  input  logic [PWM_BITS-1:0] i_led_duty,
  output logic [NUM_LED-1:0]  o_led
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;
  logic                pwm_on;

  // One independent debouncer per switch channel.
  generate
    for (genvar k = 0; k < NUM_SW; k++) begin : g_sw
      board_io_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (i_sw[k]),
        .level (o_sw_db[k]),
        .rise  (o_sw_rise[k]),
        .fall  (o_sw_fall[k])
      );
    end
  endgenerate

  // Free-running PWM period counter; duty is sampled only on the last count
  // so brightness never changes partway through a period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == PWM_MAX) begin
        duty_q <= i_led_duty;
      end
    end
  end

  // Full-scale duty forces constant on so there is no dropout at the wrap.
  assign pwm_on = (duty_q == PWM_MAX) | (pwm_cnt < duty_q);

  // Registered LED drive keeps the pins glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_led <= '0;
    end else begin
      o_led <= i_led & {NUM_LED{pwm_on}};
    end
  end

endmodule
`default_nettype wire
